// File: rtl/example_data_memory_arbiter_if.sv
// rtl/example_data_memory_arbiter_if.sv - requester and data memory bus signals for the two-port arbiter
// Lock inputs exist only when DATA_ARB_LOCK_EN is defined.
interface example_data_memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  p0_req,    p1_req;
    logic [ADDR_WIDTH-1:0] p0_addr,   p1_addr;
    logic                  p0_we,     p1_we;
    logic [BE_WIDTH-1:0]   p0_be,     p1_be;
    logic [DATA_WIDTH-1:0] p0_wdata,  p1_wdata;
    logic                  p0_gnt,    p1_gnt;
    logic                  p0_rvalid, p1_rvalid;
    logic [DATA_WIDTH-1:0] p0_rdata,  p1_rdata;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_write_enable;
    logic [BE_WIDTH-1:0]   mem_byte_enable;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_read_enable;
    logic [DATA_WIDTH-1:0] mem_read_data;

`ifdef DATA_ARB_LOCK_EN
    logic                  p0_lock,   p1_lock;

    modport master (
        output p0_req, p0_addr, p0_we, p0_be, p0_wdata, p0_lock,
        output p1_req, p1_addr, p1_we, p1_be, p1_wdata, p1_lock,
        input  p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
        input  mem_address, mem_write_enable, mem_byte_enable, mem_write_data, mem_read_enable,
        output mem_read_data
    );

    modport slave (
        input  p0_req, p0_addr, p0_we, p0_be, p0_wdata, p0_lock,
        input  p1_req, p1_addr, p1_we, p1_be, p1_wdata, p1_lock,
        output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
        output mem_address, mem_write_enable, mem_byte_enable, mem_write_data, mem_read_enable,
        input  mem_read_data
    );
`else
    modport master (
        output p0_req, p0_addr, p0_we, p0_be, p0_wdata,
        output p1_req, p1_addr, p1_we, p1_be, p1_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
        input  mem_address, mem_write_enable, mem_byte_enable, mem_write_data, mem_read_enable,
        output mem_read_data
    );

    modport slave (
        input  p0_req, p0_addr, p0_we, p0_be, p0_wdata,
        input  p1_req, p1_addr, p1_we, p1_be, p1_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
        output mem_address, mem_write_enable, mem_byte_enable, mem_write_data, mem_read_enable,
        input  mem_read_data
    );
`endif
endinterface

// File: rtl/example_data_memory_arbiter.sv
// rtl/example_data_memory_arbiter.sv - round-robin arbiter of LSU (port 0) and DMA/debug (port 1) onto the data bus
// Optional grant locking is built when DATA_ARB_LOCK_EN is defined.
module example_data_memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
`ifdef DATA_ARB_LOCK_EN
    ,
    parameter int MAX_LOCK_BEATS = 8
`endif
) (
    input  logic                         clock,
    input  logic                         reset,
    example_data_memory_arbiter_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  w_p0_win, w_p1_win, w_accept, w_sel, w_we, w_tie;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [BE_WIDTH-1:0]   w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_p0_rvalid, w_p1_rvalid;
    logic                  r_last_grant, r_rvalid, r_owner;

`ifdef DATA_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_LOCK_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LOCK_BEATS - 1);

    typedef enum logic [1:0] {S_OPEN, S_LOCKED0, S_LOCKED1} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
    logic             w_lock;
`endif

    assign w_tie = bus.p0_req && bus.p1_req;

    // r_last_grant = 1 means port 1 was served last, so port 0 wins a tie.
    always_comb begin
        w_p0_win = bus.p0_req && (!w_tie || r_last_grant);
        w_p1_win = bus.p1_req && (!w_tie || !r_last_grant);
`ifdef DATA_ARB_LOCK_EN
        if (r_state == S_LOCKED0) begin
            w_p0_win = bus.p0_req;
            w_p1_win = 1'b0;
        end else if (r_state == S_LOCKED1) begin
            w_p0_win = 1'b0;
            w_p1_win = bus.p1_req;
        end
`endif
        if (reset) begin
            w_p0_win = 1'b0;
            w_p1_win = 1'b0;
        end
    end

    assign w_accept = w_p0_win || w_p1_win;
    assign w_sel    = w_p1_win;
    assign w_we     = w_sel ? bus.p1_we : bus.p0_we;
    assign w_addr   = w_p0_win ? bus.p0_addr  : (w_p1_win ? bus.p1_addr  : '0);
    assign w_be     = w_p0_win ? bus.p0_be    : (w_p1_win ? bus.p1_be    : '0);
    assign w_wdata  = w_p0_win ? bus.p0_wdata : (w_p1_win ? bus.p1_wdata : '0);

    assign bus.p0_gnt           = w_p0_win;
    assign bus.p1_gnt           = w_p1_win;
    assign bus.mem_address      = w_addr;
    assign bus.mem_byte_enable  = w_be;
    assign bus.mem_write_data   = w_wdata;
    assign bus.mem_read_enable  = w_accept && !w_we;
    assign bus.mem_write_enable = w_accept && w_we;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_rvalid     <= 1'b0;
            r_owner      <= 1'b0;
        end else begin
            r_rvalid <= w_accept && !w_we;
            if (w_accept) begin
                r_last_grant <= w_sel;
            end
            if (w_accept && !w_we) begin
                r_owner <= w_sel;
            end
        end
    end

    // Gating with reset drops a read whose data would return during reset.
    assign w_p0_rvalid   = r_rvalid && !r_owner && !reset;
    assign w_p1_rvalid   = r_rvalid && r_owner && !reset;
    assign bus.p0_rvalid = w_p0_rvalid;
    assign bus.p1_rvalid = w_p1_rvalid;
    assign bus.p0_rdata  = w_p0_rvalid ? bus.mem_read_data : '0;
    assign bus.p1_rdata  = w_p1_rvalid ? bus.mem_read_data : '0;

`ifdef DATA_ARB_LOCK_EN
    assign w_lock = w_sel ? bus.p1_lock : bus.p0_lock;

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        if (w_accept) begin
            if (w_lock && (r_lock_cnt < LAST_CNT)) begin
                w_state_nxt    = w_sel ? S_LOCKED1 : S_LOCKED0;
                w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
            end else begin
                w_state_nxt    = S_OPEN;
                w_lock_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_OPEN;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_example_data_memory_arbiter.sv
// tb/tb_example_data_memory_arbiter.sv - scoreboard bench for the two-port data memory arbiter
module tb_example_data_memory_arbiter;
    typedef struct packed {
        logic        req;
        logic        we;
        logic        lock;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    localparam int MAX_LOCK = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    logic m_last;
    int   m_state;
    int   m_cnt;
    int   last_win;

    example_data_memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    example_data_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    always @(posedge clock) begin
        bus.mem_read_data <= bus.mem_read_enable ? mem_f(bus.mem_address) : 32'h0;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic req_t idle();
        req_t q;
        q = '0;
        return q;
    endfunction

    function automatic req_t rd(input logic [31:0] a);
        req_t q;
        q = '0;
        q.req = 1'b1;
        q.addr = a;
        return q;
    endfunction

    function automatic req_t wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        req_t q;
        q = '0;
        q.req = 1'b1;
        q.we = 1'b1;
        q.addr = a;
        q.be = be;
        q.wdata = d;
        return q;
    endfunction

    function automatic int model_winner(input logic r0, input logic r1);
        if (m_state == 1) return r0 ? 0 : -1;
        if (m_state == 2) return r1 ? 1 : -1;
        if (r0 && r1) return m_last ? 0 : 1;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic void model_accept(input int win, input logic lk);
        m_last = (win == 1);
`ifdef DATA_ARB_LOCK_EN
        if (lk && (m_cnt + 1 < MAX_LOCK)) begin
            m_state = win + 1;
            m_cnt++;
        end else begin
            m_state = 0;
            m_cnt = 0;
        end
`else
        if (lk) m_state = 0;
`endif
    endfunction

    function automatic void model_reset();
        sb.delete();
        m_last = 1'b1;
        m_state = 0;
        m_cnt = 0;
    endfunction

    task automatic apply(input req_t q0, input req_t q1);
        bus.p0_req = q0.req;  bus.p0_we = q0.we;  bus.p0_addr = q0.addr;
        bus.p0_be  = q0.be;   bus.p0_wdata = q0.wdata;
        bus.p1_req = q1.req;  bus.p1_we = q1.we;  bus.p1_addr = q1.addr;
        bus.p1_be  = q1.be;   bus.p1_wdata = q1.wdata;
`ifdef DATA_ARB_LOCK_EN
        bus.p0_lock = q0.lock;
        bus.p1_lock = q1.lock;
`endif
    endtask

    task automatic check_rdata();
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("p0_rvalid", bus.p0_rvalid, e.port == 1'b0);
            check_eq("p1_rvalid", bus.p1_rvalid, e.port == 1'b1);
            check_eq("p0_rdata", bus.p0_rdata, (e.port == 1'b0) ? e.data : 32'h0);
            check_eq("p1_rdata", bus.p1_rdata, (e.port == 1'b1) ? e.data : 32'h0);
        end else begin
            check_eq("p0_rvalid_idle", bus.p0_rvalid, 1'b0);
            check_eq("p1_rvalid_idle", bus.p1_rvalid, 1'b0);
        end
    endtask

    // One bus cycle: drive at the falling edge, sample 1 ns later, model advances for the next rising edge.
    task automatic drive(input req_t q0, input req_t q1);
        int   win;
        req_t w;
        exp_t e;
        @(negedge clock);
        apply(q0, q1);
        #1;
        win = model_winner(q0.req, q1.req);
        w = (win == 1) ? q1 : q0;
        check_eq("p0_gnt", bus.p0_gnt, win == 0);
        check_eq("p1_gnt", bus.p1_gnt, win == 1);
        check_eq("mem_read_enable", bus.mem_read_enable, (win >= 0) && !w.we);
        check_eq("mem_write_enable", bus.mem_write_enable, (win >= 0) && w.we);
        check_eq("mem_address", bus.mem_address, (win >= 0) ? w.addr : 32'h0);
        check_eq("mem_byte_enable", bus.mem_byte_enable, (win >= 0) ? w.be : 4'h0);
        check_eq("mem_write_data", bus.mem_write_data, (win >= 0) ? w.wdata : 32'h0);
        check_rdata();
        if (win >= 0) begin
            if (!w.we) begin
                e.port = (win == 1);
                e.data = mem_f(w.addr);
                sb.push_back(e);
            end
            model_accept(win, w.lock);
        end
        last_win = win;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        apply(idle(), idle());
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        req_t r0, r1;
        req_t lq0;
        int   beats0;
        int   seq[$];

        model_reset();
        last_win = -1;
        apply(rd(32'h0000_1000), wr(32'h0000_2000, 4'hF, 32'h1234_5678));
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check_eq("rst_p0_gnt", bus.p0_gnt, 1'b0);
        check_eq("rst_p1_gnt", bus.p1_gnt, 1'b0);
        check_eq("rst_rd_en", bus.mem_read_enable, 1'b0);
        check_eq("rst_wr_en", bus.mem_write_enable, 1'b0);
        check_eq("rst_p0_rvalid", bus.p0_rvalid, 1'b0);
        check_eq("rst_p1_rvalid", bus.p1_rvalid, 1'b0);
        apply(idle(), idle());
        reset = 1'b0;

        // Lone read from port 0.
        drive(rd(32'h8000_0010), idle());
        check_eq("t1_p0_gnt", bus.p0_gnt, 1'b1);
        check_eq("t1_addr", bus.mem_address, 32'h8000_0010);
        drive(idle(), idle());
        check_eq("t1_p0_rvalid", bus.p0_rvalid, 1'b1);
        check_eq("t1_p0_rdata", bus.p0_rdata, mem_f(32'h8000_0010));

        // Both ports reading continuously alternate starting with port 0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(rd(32'h0000_0100), rd(32'h0000_0200));
            check_eq("rr_seq", last_win, i % 2);
        end
        drive(idle(), idle());

        // Write from port 0 beats a simultaneous read from port 1.
        do_reset();
        drive(wr(32'h8000_0020, 4'b0011, 32'hDEAD_BEEF), rd(32'h8000_0040));
        check_eq("t3_p0_gnt", bus.p0_gnt, 1'b1);
        check_eq("t3_wr_en", bus.mem_write_enable, 1'b1);
        check_eq("t3_be", bus.mem_byte_enable, 4'b0011);
        check_eq("t3_wdata", bus.mem_write_data, 32'hDEAD_BEEF);
        drive(idle(), rd(32'h8000_0040));
        check_eq("t3_p1_gnt", bus.p1_gnt, 1'b1);
        check_eq("t3_no_p0_rvalid", bus.p0_rvalid, 1'b0);
        drive(idle(), idle());

        // Reset right after a read accept cancels the returning data.
        drive(idle(), rd(32'h8000_0050));
        @(negedge clock);
        reset = 1'b1;
        apply(rd(32'h0000_0060), rd(32'h0000_0070));
        #1;
        check_eq("t4_p1_rvalid", bus.p1_rvalid, 1'b0);
        check_eq("t4_p0_gnt", bus.p0_gnt, 1'b0);
        check_eq("t4_p1_gnt", bus.p1_gnt, 1'b0);
        check_eq("t4_rd_en", bus.mem_read_enable, 1'b0);
        check_eq("t4_wr_en", bus.mem_write_enable, 1'b0);
        model_reset();
        @(negedge clock);
        apply(idle(), idle());
        reset = 1'b0;

        // Idle bus.
        repeat (4) drive(idle(), idle());

        // Random traffic; each request is held until granted.
        r0 = idle();
        r1 = idle();
        for (int i = 0; i < 80; i++) begin
            if (!r0.req && $urandom_range(0, 2) != 0) begin
                r0 = $urandom_range(0, 1) ? rd($urandom) : wr($urandom, 4'($urandom), $urandom);
                r0.lock = ($urandom_range(0, 3) == 0);
            end
            if (!r1.req && $urandom_range(0, 2) != 0) begin
                r1 = $urandom_range(0, 1) ? rd($urandom) : wr($urandom, 4'($urandom), $urandom);
                r1.lock = ($urandom_range(0, 3) == 0);
            end
            drive(r0, r1);
            if (last_win == 0) r0 = idle();
            if (last_win == 1) r1 = idle();
        end
        drive(idle(), idle());

`ifdef DATA_ARB_LOCK_EN
        // Locked port 0 is forced to release after MAX_LOCK beats.
        do_reset();
        lq0 = rd(32'h0000_0300);
        lq0.lock = 1'b1;
        beats0 = 0;
        for (int c = 0; c < 24 && beats0 < 10; c++) begin
            drive(lq0, rd(32'h0000_0400));
            if (last_win >= 0) seq.push_back(last_win);
            if (last_win == 0) beats0++;
        end
        check_eq("lock_beats", beats0, 10);
        check_eq("lock_seq_len", seq.size(), 11);
        for (int i = 0; i < 11; i++) begin
            if (i < seq.size()) check_eq("lock_seq", seq[i], (i == 8) ? 1 : 0);
        end
        drive(idle(), idle());
`else
        lq0 = idle();
        beats0 = 0;
        seq.delete();
`endif

        drive(idle(), idle());
        check_eq("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
